// File: rtl/serial_pattern_gen_if.sv
// Bus bundle for serial_pattern_gen: pattern/control inputs and the serial output side.
// master drives the pattern and pushbuttons; slave is the generator.
interface serial_pattern_gen_if #(
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(WIDTH + 1)
);
    logic [WIDTH-1:0] pattern;
    logic [LW-1:0]    len;
    logic             start;
    logic             step;
    logic             auto_mode;
    logic             repeat_en;
    logic             sdata;
    logic             sclk;
    logic             busy;
    logic             done;
    logic [LW-1:0]    bitidx;

    modport master (
        output pattern, len, start, step, auto_mode, repeat_en,
        input  sdata, sclk, busy, done, bitidx
    );

    modport slave (
        input  pattern, len, start, step, auto_mode, repeat_en,
        output sdata, sclk, busy, done, bitidx
    );
endinterface

// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first with a one-cycle
// sclk strobe per bit, advanced by a debounced step button or an internal divider.
module serial_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int DIV   = 50
) (
    input logic                 hz100,
    input logic                 reset,
    serial_pattern_gen_if.slave bus
);
    localparam int LW = $clog2(WIDTH + 1);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [LW-1:0] WIDTH_L  = LW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        DONE
    } state_t;

    state_t state, state_n;

    logic [1:0]       start_sync, step_sync;
    logic             start_prev, step_prev;
    logic             start_ev, step_ev;

    logic [WIDTH-1:0] shadow, shadow_n;
    logic [LW-1:0]    len_q, len_n;
    logic [LW-1:0]    bitidx_q, bitidx_n;
    logic [LW-1:0]    eff_len, eff_len_n, sel_n;
    logic [DW-1:0]    div_q, div_n;
    logic             last_bit;
    logic             sdata_n;
    logic             sdata_q, sclk_q, busy_q, done_q;

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            start_sync <= '0;
            step_sync  <= '0;
            start_prev <= 1'b0;
            step_prev  <= 1'b0;
        end else begin
            start_sync <= {start_sync[0], bus.start};
            step_sync  <= {step_sync[0], bus.step};
            start_prev <= start_sync[1];
            step_prev  <= step_sync[1];
        end
    end

    assign start_ev = start_sync[1] & ~start_prev;
    assign step_ev  = step_sync[1] & ~step_prev;

    // A latched len of 0 or beyond WIDTH means "send the full WIDTH bits".
    assign eff_len  = (len_q == '0 || len_q > WIDTH_L) ? WIDTH_L : len_q;
    assign last_bit = (bitidx_q == eff_len - LW'(1));

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        shadow_n = shadow;
        len_n    = len_q;
        bitidx_n = bitidx_q;
        div_n    = div_q;
        case (state)
            IDLE: begin
                bitidx_n = '0;
                if (start_ev) begin
                    shadow_n = bus.pattern;
                    len_n    = bus.len;
                    div_n    = '0;
                    state_n  = SETUP;
                end
            end
            SETUP: begin
                if (bus.auto_mode) begin
                    if (div_q == DIV_LAST) state_n = STROBE;
                    else                   div_n   = div_q + 1'b1;
                end else if (step_ev) begin
                    state_n = STROBE;
                end
            end
            STROBE: begin
                div_n = '0;
                if (!last_bit) begin
                    bitidx_n = bitidx_q + 1'b1;
                    state_n  = SETUP;
                end else if (bus.repeat_en) begin
                    bitidx_n = '0;
                    state_n  = SETUP;
                end else begin
                    bitidx_n = eff_len;
                    state_n  = DONE;
                end
            end
            DONE: begin
                bitidx_n = '0;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered from next-state values so they track the state with no lag.
        eff_len_n = (len_n == '0 || len_n > WIDTH_L) ? WIDTH_L : len_n;
        sel_n     = eff_len_n - LW'(1) - bitidx_n;
        sdata_n   = 1'b0;
        if (state_n == SETUP || state_n == STROBE) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (LW'(i) == sel_n) sdata_n = shadow_n[i];
            end
        end
    end

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            shadow   <= '0;
            len_q    <= '0;
            bitidx_q <= '0;
            div_q    <= '0;
            sdata_q  <= 1'b0;
            sclk_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            shadow   <= shadow_n;
            len_q    <= len_n;
            bitidx_q <= bitidx_n;
            div_q    <= div_n;
            sdata_q  <= sdata_n;
            sclk_q   <= (state_n == STROBE);
            busy_q   <= (state_n == SETUP) || (state_n == STROBE);
            done_q   <= (state_n == DONE);
        end
    end

    assign bus.sdata  = sdata_q;
    assign bus.sclk   = sclk_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.bitidx = bitidx_q;
endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen: table of single passes plus hand-written
// sequences for latency, reset abort and repeat mode. Instance a uses DIV=4, b uses DIV=2.
module tb_serial_pattern_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pattern = '0;
    logic [3:0] len = '0;
    logic       start = 1'b0, step = 1'b0, auto_mode = 1'b0, repeat_en = 1'b0;
    logic       sel = 1'b0;

    always #5 clk = ~clk;

    serial_pattern_gen_if #(.WIDTH(8)) if_a ();
    serial_pattern_gen_if #(.WIDTH(8)) if_b ();

    assign if_a.pattern = pattern;   assign if_b.pattern = pattern;
    assign if_a.len = len;           assign if_b.len = len;
    assign if_a.start = start;       assign if_b.start = start;
    assign if_a.step = step;         assign if_b.step = step;
    assign if_a.auto_mode = auto_mode; assign if_b.auto_mode = auto_mode;
    assign if_a.repeat_en = repeat_en; assign if_b.repeat_en = repeat_en;

    serial_pattern_gen #(.WIDTH(8), .DIV(4)) u_dut_a (.hz100(clk), .reset(rst), .bus(if_a));
    serial_pattern_gen #(.WIDTH(8), .DIV(2)) u_dut_b (.hz100(clk), .reset(rst), .bus(if_b));

    logic       o_sdata, o_sclk, o_busy, o_done;
    logic [3:0] o_bitidx;
    assign o_sdata  = sel ? if_b.sdata  : if_a.sdata;
    assign o_sclk   = sel ? if_b.sclk   : if_a.sclk;
    assign o_busy   = sel ? if_b.busy   : if_a.busy;
    assign o_done   = sel ? if_b.done   : if_a.done;
    assign o_bitidx = sel ? if_b.bitidx : if_a.bitidx;

    int passed = 0;
    int total  = 0;

    // Monitor state is owned by the monitor; the test bumps epoch to request a clear.
    int epoch = 0, seen_epoch = 0, mon_L = 1;
    int cyc = 0, strobes = 0, dones = 0, zero_cnt = 0;
    int stab_err = 0, bidx_err = 0, done_err = 0;
    int last_cyc = -1, min_gap = 1000, max_gap = 0;
    logic [31:0] bits = '0;
    logic prev_busy = 1'b0, prev_sdata = 1'b0, prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            strobes = 0; dones = 0; zero_cnt = 0;
            stab_err = 0; bidx_err = 0; done_err = 0;
            last_cyc = -1; min_gap = 1000; max_gap = 0; bits = '0;
        end
        cyc++;
        if (o_sclk) begin
            if (last_cyc >= 0) begin
                if (cyc - last_cyc < min_gap) min_gap = cyc - last_cyc;
                if (cyc - last_cyc > max_gap) max_gap = cyc - last_cyc;
            end
            last_cyc = cyc;
            if (!(prev_busy && o_busy && prev_sdata == o_sdata)) stab_err++;
            if (int'(o_bitidx) != strobes % mon_L) bidx_err++;
            bits = {bits[30:0], o_sdata};
            if (!o_sdata) zero_cnt++;
            strobes++;
        end
        if (o_done) begin
            dones++;
            if (!prev_sclk || o_busy || o_sdata || int'(o_bitidx) != mon_L) done_err++;
        end
        prev_busy = o_busy; prev_sdata = o_sdata; prev_sclk = o_sclk;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; step = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic clear_mon();
        epoch++;
        tick(1);
    endtask

    typedef struct {
        logic [7:0] pat;
        logic [3:0] ln;
        logic       am;
        int         exp_n;
        logic [7:0] exp_bits;
    } vec_t;

    vec_t vecs[8];
    int   found;

    initial begin
        vecs[0] = '{8'h0B, 4'd4,  1'b0, 4, 8'h0B};
        vecs[1] = '{8'hA5, 4'd0,  1'b1, 8, 8'hA5};
        vecs[2] = '{8'hFF, 4'd12, 1'b1, 8, 8'hFF};
        vecs[3] = '{8'h01, 4'd1,  1'b1, 1, 8'h01};
        vecs[4] = '{8'h6D, 4'd5,  1'b0, 5, 8'h0D};
        vecs[5] = '{8'h5A, 4'd8,  1'b1, 8, 8'h5A};
        vecs[6] = '{8'hE4, 4'd3,  1'b1, 3, 8'h04};
        vecs[7] = '{8'h80, 4'd0,  1'b0, 8, 8'h80};

        // Reset values while reset is held.
        tick(2);
        check("rst_sdata", o_sdata, 0);
        check("rst_sclk", o_sclk, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_bitidx", o_bitidx, 0);

        // Table of single passes; steps are pulsed throughout (ignored in auto mode).
        for (int v = 0; v < 8; v++) begin
            sel = 1'b0;
            do_reset();
            mon_L = vecs[v].exp_n;
            clear_mon();
            pattern = vecs[v].pat; len = vecs[v].ln;
            auto_mode = vecs[v].am; repeat_en = 1'b0;
            start = 1'b1; tick(3); start = 1'b0;
            for (int i = 0; i < 400; i++) begin
                tick(1);
                step = ((i % 6) < 2);
                if (dones > 0) break;
            end
            step = 1'b0;
            tick(6);
            check($sformatf("v%0d_dones", v), dones, 1);
            check($sformatf("v%0d_strobes", v), strobes, vecs[v].exp_n);
            check($sformatf("v%0d_bits", v), int'(bits & ((32'd1 << vecs[v].exp_n) - 32'd1)),
                  int'(vecs[v].exp_bits));
            check($sformatf("v%0d_stable", v), stab_err, 0);
            check($sformatf("v%0d_bitidx", v), bidx_err, 0);
            check($sformatf("v%0d_donepulse", v), done_err, 0);
            if (vecs[v].am && vecs[v].exp_n > 1) begin
                check($sformatf("v%0d_mingap", v), min_gap, 5);
                check($sformatf("v%0d_maxgap", v), max_gap, 5);
            end
        end

        // Handshake: start latency, held start, busy-time start and pattern change.
        sel = 1'b0;
        do_reset();
        mon_L = 8;
        clear_mon();
        pattern = 8'hC3; len = 4'd8; auto_mode = 1'b1; repeat_en = 1'b0;
        start = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("hs_busy_k1", o_busy, 0);
        @(negedge clk);
        check("hs_busy_k2", o_busy, 1);
        tick(1);
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (i == 4) pattern = 8'h00;
        end
        start = 1'b0;
        tick(4);
        start = 1'b1; tick(2); start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (dones > 0) break;
        end
        tick(30);
        check("hs_dones", dones, 1);
        check("hs_strobes", strobes, 8);
        check("hs_bits", int'(bits[7:0]), 32'hC3);
        check("hs_donepulse", done_err, 0);

        // Reset during the second SETUP aborts the pass with no done pulse.
        sel = 1'b0;
        do_reset();
        mon_L = 8;
        clear_mon();
        pattern = 8'hFF; len = 4'd0; auto_mode = 1'b0;
        start = 1'b1; tick(3); start = 1'b0; tick(3);
        step = 1'b1; tick(2); step = 1'b0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_busy && o_bitidx == 4'd1 && !o_sclk) begin
                found = 1;
                break;
            end
        end
        check("abort_reach_setup2", found, 1);
        #1 rst = 1'b1;
        #1;
        check("abort_sdata", o_sdata, 0);
        check("abort_sclk", o_sclk, 0);
        check("abort_busy", o_busy, 0);
        check("abort_bitidx", o_bitidx, 0);
        check("abort_done", o_done, 0);
        @(posedge clk); #1 rst = 1'b0;
        clear_mon();
        tick(20);
        check("abort_no_done", dones, 0);
        check("abort_idle", o_busy, 0);

        // Repeat mode on the DIV=2 instance, then drop repeat_en mid-pass.
        sel = 1'b1;
        do_reset();
        mon_L = 2;
        clear_mon();
        pattern = 8'h03; len = 4'd2; auto_mode = 1'b1; repeat_en = 1'b1;
        start = 1'b1; tick(3); start = 1'b0;
        tick(45);
        check("rep_no_done", dones, 0);
        check("rep_many", (strobes >= 10) ? 1 : 0, 1);
        check("rep_all_ones", zero_cnt, 0);
        check("rep_mingap", min_gap, 3);
        check("rep_maxgap", max_gap, 3);
        check("rep_bitidx", bidx_err, 0);
        repeat_en = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (dones > 0) break;
        end
        tick(10);
        check("rep_final_done", dones, 1);
        check("rep_whole_passes", strobes % 2, 0);
        check("rep_donepulse", done_err, 0);
        check("rep_stable", stab_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/serial_pattern_gen.md
Name: serial_pattern_gen

Overview:
- Transmit-side counterpart to the pushbutton-clocked serial sequence detectors.
- Loads a bit pattern and shifts it out MSB-first on sdata, with a one-cycle sclk strobe per bit, so it can drive a detector's CLK/S inputs directly.
- Bit advance comes from either a debounced step pushbutton or an internal hz100 divider.
- Provides start/busy/done handshake and optional repeat.

Parameters:
- WIDTH, 8: maximum pattern length in bits.
- DIV, 50: hz100 cycles per bit in auto mode. Legal range is DIV ≥ 1.
- LW, $clog2(WIDTH+1): width of the len and bitidx ports. Derived; not overridden.

Ports:
- hz100  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- pattern  input  WIDTH  bits to send. Latched on accepted start.
- len  input  LW  number of bits to send. Latched on accepted start.
- start  input  1  raw pushbutton level. Rising edge requests a pass.
- step  input  1  raw pushbutton level. Rising edge advances one bit in manual mode.
- auto_mode  input  1  1 = divider advances bits; 0 = step advances bits. Sampled every cycle.
- repeat_en  input  1  1 = restart the pattern after the last bit. Sampled at end of each pass.
- sdata  output  1  serial data bit.
- sclk  output  1  bit strobe, high exactly one cycle per bit.
- busy  output  1  high from accepted start until DONE.
- done  output  1  one-cycle pulse at end of final pass.
- bitidx  output  LW  bits already strobed in current pass.

Behaviour:
- Reset, asynchronous: state=IDLE; sdata=0, sclk=0, busy=0, done=0, bitidx=0; shadow regs, divider and synchronizers = 0.
- Input conditioning:
  - start and step each pass through a 2-flop synchronizer followed by a rising-edge detector (sync2 & ~prev).
  - An input first sampled high at edge k produces its effect at edge k+2.
  - A held input produces exactly one event.
- Effective length: L = WIDTH if the latched len is 0 or greater than WIDTH; otherwise L = len.
- Current bit: sdata = shadow[L-1-bitidx], i.e. MSB of the L-bit field first.
- IDLE:
  - sdata=0, busy=0, bitidx=0.
  - On a start event: latch pattern and len, clear bitidx and divider, go to SETUP.
- SETUP:
  - busy=1, sdata = current bit, sclk=0.
  - Advance event when auto_mode=1: divider reaches DIV-1. Divider is cleared on every SETUP entry and increments each SETUP cycle.
  - Advance event when auto_mode=0: a step event. Divider is held.
  - Step events while auto_mode=1 are ignored.
  - On an advance event: go to STROBE.
- STROBE (one cycle only):
  - sclk=1, sdata unchanged, so data is stable ≥1 cycle before and during the strobe.
  - Next state:
    - bitidx < L-1: bitidx+1, go to SETUP.
    - Last bit and repeat_en=1: bitidx=0, go to SETUP. Pattern is not re-latched.
    - Last bit and repeat_en=0: go to DONE.
- DONE (one cycle):
  - done=1, busy=0, sdata=0, bitidx=L.
  - Next cycle: go to IDLE and clear bitidx.
- Auto-mode bit period is exactly DIV+1 cycles (DIV in SETUP + 1 in STROBE).
- Start events while busy=1 (SETUP/STROBE) are ignored; the pattern is not re-latched.
- A start event arriving in the DONE cycle is also ignored.
- Changes to pattern/len while busy have no effect until the next accepted start.
- Reset mid-pass aborts immediately: outputs return to reset values, and no done pulse is issued.
- All outputs are registered. No combinational path from any input to any output.

Test Plan:
- Reset mid-pass: assert reset during the 2nd SETUP of a pass → same cycle sdata=0, sclk=0, busy=0, bitidx=0; no done pulse afterward.
- Manual send: pattern=8'h0B, len=4, auto_mode=0, start pulse, then 4 step pulses → exactly 4 sclk pulses with sdata=1,0,1,1 at each; bitidx 0→1→2→3; done high one cycle after the 4th strobe; busy low from that cycle.
- Auto timing: DIV=4, pattern=8'hA5, len=0 → 8 sclk pulses spaced 5 cycles apart, sdata sequence 1,0,1,0,0,1,0,1; step pulses during the pass produce no extra strobes; single done pulse.
- Length clamp: len=12, pattern=8'hFF → exactly 8 strobes. len=1, pattern=8'h01 → exactly 1 strobe with sdata=1.
- Repeat: pattern=8'h03, len=2, DIV=2, repeat_en=1 → strobes 1,1,1,1,… with no done. Drop repeat_en mid-pass → current pass completes, then done pulses once.
- Handshake: hold start high 20 cycles, then a second start pulse while busy → one pass only (one done); the first event is taken at edge k+2 of the start rise; pattern changed mid-pass does not alter the sdata sequence.
